// File: rtl/debug_unit_pkg.sv
// ============================================================================
// Module      : debug_unit_pkg
// Description : Shared widths, command codes and FSM states of the debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_unit_pkg;

    localparam int LEN       = 32;
    localparam int NB_BYTE   = 8;
    localparam int IM_DEPTH  = 256;

    localparam int NB_IF_ID  = 96;
    localparam int NB_ID_EX  = 224;
    localparam int NB_EX_MEM = 128;
    localparam int NB_MEM_WB = 96;
    localparam int NB_DUMP   = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int N_DUMP_BYTES = NB_DUMP / NB_BYTE;

    localparam logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h01;
    localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h02;
    localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h03;
    localparam logic [NB_BYTE-1:0] CMD_EXEC  = 8'h04;
    localparam logic [NB_BYTE-1:0] CMD_ABORT = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_BYTE  = 3'd1,
        ST_LOAD_WRITE = 3'd2,
        ST_RUN        = 3'd3,
        ST_STEP_WAIT  = 3'd4,
        ST_STEP_EXEC  = 3'd5,
        ST_DUMP_SEND  = 3'd6,
        ST_DUMP_WAIT  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/debug_unit_if.sv
// ============================================================================
// Module      : debug_unit_if
// Description : UART, instruction-load and pipeline-control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_unit_if
    import debug_unit_pkg::*;
();

    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic               i_halt;
    logic [NB_DUMP-1:0] i_dump_data;
    logic               o_wea_mem_instr;
    logic [LEN-1:0]     o_addr_mem_instr;
    logic [LEN-1:0]     o_dato_mem_instr;
    logic               o_pipe_rst;
    logic               o_pipe_enable;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;

    // The debug unit drives the pipeline and UART, so it is the master.
    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_dump_data,
        output o_wea_mem_instr, o_addr_mem_instr, o_dato_mem_instr,
               o_pipe_rst, o_pipe_enable, o_tx_data, o_tx_start, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_halt, i_dump_data,
        input  o_wea_mem_instr, o_addr_mem_instr, o_dato_mem_instr,
               o_pipe_rst, o_pipe_enable, o_tx_data, o_tx_start, o_busy
    );

endinterface

`default_nettype wire

// File: rtl/debug_unit_dump_serializer.sv
// ============================================================================
// Module      : dump_serializer
// Description : Captures the latch snapshot and sends it MSB-first over UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dump_serializer
    import debug_unit_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_capture,
    input  logic [NB_DUMP-1:0] i_dump_data,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    localparam int c_cnt_w = $clog2(N_DUMP_BYTES + 1);

    logic [NB_DUMP-1:0] r_shift;
    logic [c_cnt_w-1:0] r_count;
    logic               r_active;
    logic               r_tx_start;
    logic               w_waiting;

    // Waiting for tx_done is every active cycle that is not the start cycle.
    assign w_waiting  = r_active & ~r_tx_start;
    assign o_done     = w_waiting & i_tx_done & (r_count == c_cnt_w'(N_DUMP_BYTES - 1));
    assign o_tx_data  = r_shift[NB_DUMP-1 -: NB_BYTE];
    assign o_tx_start = r_tx_start;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_shift    <= '0;
            r_count    <= '0;
            r_active   <= 1'b0;
            r_tx_start <= 1'b0;
        end else if (i_capture) begin
            r_shift    <= i_dump_data;
            r_count    <= '0;
            r_active   <= 1'b1;
            r_tx_start <= 1'b1;
        end else if (r_tx_start) begin
            r_tx_start <= 1'b0;
        end else if (w_waiting && i_tx_done) begin
            r_shift <= r_shift << NB_BYTE;
            r_count <= r_count + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_tx_start <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_unit.sv
// ============================================================================
// Module      : debug_unit
// Description : Host command FSM: instruction load, run/step control, dumps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_unit
    import debug_unit_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    debug_unit_if.master bus
);

    state_t           r_state;
    logic             r_step_mode;
    logic             r_halt_seen;
    logic             r_pipe_rst;
    logic             r_pipe_enable;
    logic             r_wea;
    logic [1:0]       r_byte_cnt;
    logic [LEN-1:0]   r_word;
    logic [LEN-1:0]   r_addr;
    logic             w_capture;
    logic             w_dump_done;

    // Snapshot is taken on the edge that ends the last enabled cycle.
    assign w_capture = ((r_state == ST_RUN) && bus.i_halt && r_pipe_enable) ||
                       (r_state == ST_STEP_EXEC);

    dump_serializer u_dump_serializer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_capture   (w_capture),
        .i_dump_data (bus.i_dump_data),
        .i_tx_done   (bus.i_tx_done),
        .o_tx_data   (bus.o_tx_data),
        .o_tx_start  (bus.o_tx_start),
        .o_done      (w_dump_done)
    );

    assign bus.o_wea_mem_instr  = r_wea;
    assign bus.o_addr_mem_instr = r_addr;
    assign bus.o_dato_mem_instr = r_word;
    assign bus.o_pipe_rst       = r_pipe_rst;
    assign bus.o_pipe_enable    = r_pipe_enable;
    assign bus.o_busy           = (r_state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_step_mode   <= 1'b0;
            r_halt_seen   <= 1'b0;
            r_pipe_rst    <= 1'b0;
            r_pipe_enable <= 1'b0;
            r_wea         <= 1'b0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_addr        <= '0;
        end else begin
            r_wea <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.i_rx_done) begin
                        case (bus.i_rx_data)
                            CMD_LOAD: begin
                                r_state    <= ST_LOAD_BYTE;
                                r_addr     <= '0;
                                r_byte_cnt <= '0;
                            end
                            CMD_RUN: begin
                                r_state       <= ST_RUN;
                                r_step_mode   <= 1'b0;
                                r_pipe_rst    <= 1'b1;
                                r_pipe_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                r_state     <= ST_STEP_WAIT;
                                r_step_mode <= 1'b1;
                                r_halt_seen <= 1'b0;
                                r_pipe_rst  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_BYTE: begin
                    if (bus.i_rx_done) begin
                        r_word <= {r_word[LEN-NB_BYTE-1:0], bus.i_rx_data};
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= '0;
                            r_wea      <= 1'b1;
                            r_state    <= ST_LOAD_WRITE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    if ((r_word == HALT_WORD) || (r_addr == LEN'(IM_DEPTH - 1))) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOAD_BYTE;
                    end
                end
                ST_RUN: begin
                    if (bus.i_halt && r_pipe_enable) begin
                        r_pipe_enable <= 1'b0;
                        r_state       <= ST_DUMP_SEND;
                    end
                end
                ST_STEP_WAIT: begin
                    if (bus.i_rx_done) begin
                        if (bus.i_rx_data == CMD_EXEC) begin
                            r_pipe_enable <= 1'b1;
                            r_state       <= ST_STEP_EXEC;
                        end else if (bus.i_rx_data == CMD_ABORT) begin
                            r_pipe_rst <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_STEP_EXEC: begin
                    r_pipe_enable <= 1'b0;
                    r_halt_seen   <= bus.i_halt;
                    r_state       <= ST_DUMP_SEND;
                end
                ST_DUMP_SEND: begin
                    r_state <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (w_dump_done) begin
                        // A halted program cannot be stepped further.
                        if (!r_step_mode || r_halt_seen) begin
                            r_pipe_rst <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_STEP_WAIT;
                        end
                    end else if (bus.i_tx_done) begin
                        r_state <= ST_DUMP_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_unit.sv
// ============================================================================
// Module      : tb_debug_unit
// Description : Self-checking bench for debug_unit against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_debug_unit;
    import debug_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    debug_unit_if bus();

    debug_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]     tx_log [0:1023];
    int             tx_n = 0;
    logic [LEN-1:0] wa_log [0:511];
    logic [LEN-1:0] wd_log [0:511];
    int             wr_n = 0;
    int             en_n = 0;

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) begin
            if (tx_n < 1024) tx_log[tx_n] = bus.o_tx_data;
            tx_n++;
        end
        if (bus.o_wea_mem_instr === 1'b1) begin
            if (wr_n < 512) begin
                wa_log[wr_n] = bus.o_addr_mem_instr;
                wd_log[wr_n] = bus.o_dato_mem_instr;
            end
            wr_n++;
        end
        if (bus.o_pipe_enable === 1'b1) en_n++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t (required finish)", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    // Four bytes MSB-first, then one idle cycle for the write slot.
    task automatic load_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            logic [31:0] t;
            t = w >> (8 * k);
            send_byte(t[7:0]);
        end
        tick();
    endtask

    function automatic logic [NB_DUMP-1:0] rand_dump();
        logic [NB_DUMP-1:0] d;
        d = '0;
        for (int k = 0; k < NB_DUMP / 32; k++) d = {d[NB_DUMP-33:0], 32'($urandom)};
        return d;
    endfunction

    // Reference: byte i of the stream is byte (67-i) of the snapshot.
    function automatic int dump_errors(input int base, input logic [NB_DUMP-1:0] d);
        int e;
        logic [NB_DUMP-1:0] t;
        e = 0;
        for (int i = 0; i < N_DUMP_BYTES; i++) begin
            t = d >> (NB_BYTE * (N_DUMP_BYTES - 1 - i));
            if (base + i >= 1024 || tx_log[base + i] !== t[7:0]) e++;
        end
        return e;
    endfunction

    // Answers n tx_start pulses; may inject 0x04 alone and with a tx_done.
    task automatic serve_dump(input int n, input int inject_at, input logic [NB_DUMP-1:0] next_dump);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (bus.o_tx_start !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (bus.o_tx_start !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL dump_timeout: byte %0d no tx_start, got=%b required=1", i, bus.o_tx_start);
                return;
            end
            if (i == 0) bus.i_dump_data = next_dump;
            tick();
            if (i == inject_at) send_byte(CMD_EXEC);
            repeat ($urandom_range(0, 2)) tick();
            bus.i_tx_done = 1'b1;
            if (i == inject_at + 1) begin
                bus.i_rx_data = CMD_EXEC;
                bus.i_rx_done = 1'b1;
            end
            tick();
            bus.i_tx_done = 1'b0;
            bus.i_rx_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.i_rx_data = CMD_LOAD;
        bus.i_rx_done = 1'b1;
        bus.i_tx_done = 1'b1;
        bus.i_halt    = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            logic [2*LEN+NB_BYTE+4:0] o;
            tick();
            o = {bus.o_wea_mem_instr, bus.o_addr_mem_instr, bus.o_dato_mem_instr, bus.o_pipe_rst,
                 bus.o_pipe_enable, bus.o_tx_data, bus.o_tx_start, bus.o_busy};
            total++;
            if (o !== '0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got=%h required=0", c, o);
            end
        end
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        bus.i_halt    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_pipe_rst !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b pipe_rst=%b required 0/0", bus.o_busy, bus.o_pipe_rst);
        end
    endtask

    task automatic test_load();
        int w0;
        w0 = wr_n;
        bus.i_halt = 1'b1;
        send_byte(8'h7E);
        total++;
        if (bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL load_stray_cmd: busy=%b required=0", bus.o_busy);
        end
        send_byte(CMD_LOAD);
        repeat ($urandom_range(0, 3)) tick();
        send_byte(8'h20);
        send_byte(8'h11);
        repeat ($urandom_range(0, 3)) tick();
        send_byte(8'h00);
        send_byte(8'h05);
        total++;
        if (bus.o_wea_mem_instr !== 1'b1) begin
            bad++;
            $display("FAIL load_write_latency: wea=%b required=1", bus.o_wea_mem_instr);
        end
        tick();
        load_word(HALT_WORD);
        bus.i_halt = 1'b0;
        total++;
        if (wr_n - w0 != 2 || wa_log[w0] !== 32'd0 || wd_log[w0] !== 32'h2011_0005 ||
            wa_log[w0+1] !== 32'd1 || wd_log[w0+1] !== HALT_WORD) begin
            bad++;
            $display("FAIL load_writes: n=%0d first=(%h,%h) second=(%h,%h) required n=2 (0,20110005) (1,ffffffff)",
                     wr_n - w0, wa_log[w0], wd_log[w0], wa_log[w0+1], wd_log[w0+1]);
        end
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_pipe_rst !== 1'b0) begin
            bad++;
            $display("FAIL load_end: busy=%b pipe_rst=%b required 0/0", bus.o_busy, bus.o_pipe_rst);
        end
    endtask

    task automatic test_load_full();
        logic [31:0] words [0:IM_DEPTH-1];
        int w0, errs;
        w0 = wr_n;
        errs = 0;
        for (int i = 0; i < IM_DEPTH; i++) begin
            do words[i] = $urandom; while (words[i] == HALT_WORD);
        end
        send_byte(CMD_LOAD);
        for (int i = 0; i < IM_DEPTH; i++) load_word(words[i]);
        for (int i = 0; i < IM_DEPTH; i++)
            if (wa_log[w0+i] !== 32'(i) || wd_log[w0+i] !== words[i]) errs++;
        total++;
        if (wr_n - w0 != IM_DEPTH || errs != 0) begin
            bad++;
            $display("FAIL load_full: writes=%0d wrong=%0d required writes=%0d wrong=0", wr_n - w0, errs, IM_DEPTH);
        end
        total++;
        if (bus.o_busy !== 1'b0 || wa_log[w0+IM_DEPTH-1] !== 32'd255) begin
            bad++;
            $display("FAIL load_full_end: busy=%b last_addr=%0d required 0/255", bus.o_busy, wa_log[w0+IM_DEPTH-1]);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
        total++;
        if (wr_n - w0 != IM_DEPTH || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL load_full_after: writes=%0d busy=%b required %0d/0", wr_n - w0, bus.o_busy, IM_DEPTH);
        end
    endtask

    task automatic test_run();
        logic [NB_DUMP-1:0] d;
        int t0, e0, errs;
        d = rand_dump();
        bus.i_dump_data = d;
        bus.i_halt = 1'b0;
        t0 = tx_n;
        e0 = en_n;
        send_byte(CMD_RUN);
        total++;
        if (bus.o_pipe_rst !== 1'b1 || bus.o_pipe_enable !== 1'b1) begin
            bad++;
            $display("FAIL run_start: pipe_rst=%b enable=%b required 1/1", bus.o_pipe_rst, bus.o_pipe_enable);
        end
        repeat (9) tick();
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        total++;
        if (bus.o_pipe_enable !== 1'b0 || bus.o_tx_start !== 1'b1 || bus.o_tx_data !== d[NB_DUMP-1 -: 8]) begin
            bad++;
            $display("FAIL run_halt: enable=%b tx_start=%b tx_data=%h required 0/1/%h",
                     bus.o_pipe_enable, bus.o_tx_start, bus.o_tx_data, d[NB_DUMP-1 -: 8]);
        end
        serve_dump(N_DUMP_BYTES, 10, rand_dump());
        errs = dump_errors(t0, d);
        total++;
        if (tx_n - t0 != N_DUMP_BYTES || errs != 0) begin
            bad++;
            $display("FAIL run_dump: bytes=%0d wrong=%0d required %0d/0", tx_n - t0, errs, N_DUMP_BYTES);
        end
        total++;
        if (en_n - e0 != 10 || bus.o_busy !== 1'b0 || bus.o_pipe_rst !== 1'b0) begin
            bad++;
            $display("FAIL run_end: enabled=%0d busy=%b pipe_rst=%b required 10/0/0", en_n - e0, bus.o_busy, bus.o_pipe_rst);
        end
    endtask

    task automatic test_step();
        logic [NB_DUMP-1:0] d;
        int t0, e0, errs;
        send_byte(CMD_STEP);
        total++;
        if (bus.o_pipe_rst !== 1'b1 || bus.o_pipe_enable !== 1'b0 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL step_enter: pipe_rst=%b enable=%b busy=%b required 1/0/1",
                     bus.o_pipe_rst, bus.o_pipe_enable, bus.o_busy);
        end
        for (int rep = 0; rep < 3; rep++) begin
            if (rep == 2) begin
                send_byte(CMD_ABORT);
                total++;
                if (bus.o_busy !== 1'b0 || bus.o_pipe_rst !== 1'b0) begin
                    bad++;
                    $display("FAIL step_abort: busy=%b pipe_rst=%b required 0/0", bus.o_busy, bus.o_pipe_rst);
                end
                send_byte(CMD_STEP);
                send_byte(8'h42);
                bus.i_halt = 1'b1;
            end
            d = rand_dump();
            bus.i_dump_data = d;
            t0 = tx_n;
            e0 = en_n;
            send_byte(CMD_EXEC);
            serve_dump(N_DUMP_BYTES, 5 + 20 * rep, rand_dump());
            bus.i_halt = 1'b0;
            errs = dump_errors(t0, d);
            total++;
            if (tx_n - t0 != N_DUMP_BYTES || errs != 0 || en_n - e0 != 1) begin
                bad++;
                $display("FAIL step_dump rep %0d: bytes=%0d wrong=%0d enabled=%0d required %0d/0/1",
                         rep, tx_n - t0, errs, en_n - e0, N_DUMP_BYTES);
            end
            tick();
            total++;
            if (bus.o_busy !== (rep < 2) || bus.o_pipe_rst !== (rep < 2) || bus.o_pipe_enable !== 1'b0) begin
                bad++;
                $display("FAIL step_after rep %0d: busy=%b pipe_rst=%b enable=%b required %b/%b/0",
                         rep, bus.o_busy, bus.o_pipe_rst, bus.o_pipe_enable, rep < 2, rep < 2);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [NB_DUMP-1:0] d;
        int n0, t0, errs;
        bus.i_dump_data = rand_dump();
        send_byte(CMD_RUN);
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        serve_dump(30, -5, rand_dump());
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_pipe_rst !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: tx_start=%b busy=%b pipe_rst=%b required 0/0/0",
                     bus.o_tx_start, bus.o_busy, bus.o_pipe_rst);
        end
        n0 = tx_n;
        bus.i_tx_done = 1'b1;
        repeat (20) tick();
        bus.i_tx_done = 1'b0;
        total++;
        if (tx_n != n0) begin
            bad++;
            $display("FAIL midreset_quiet: extra tx_start=%0d required 0", tx_n - n0);
        end
        d = rand_dump();
        bus.i_dump_data = d;
        t0 = tx_n;
        send_byte(CMD_RUN);
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        serve_dump(N_DUMP_BYTES, -5, rand_dump());
        errs = dump_errors(t0, d);
        total++;
        if (tx_n - t0 != N_DUMP_BYTES || errs != 0 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_redump: bytes=%0d wrong=%0d busy=%b required %0d/0/0",
                     tx_n - t0, errs, bus.o_busy, N_DUMP_BYTES);
        end
    endtask

    initial begin
        bus.i_rx_data   = '0;
        bus.i_rx_done   = 1'b0;
        bus.i_tx_done   = 1'b0;
        bus.i_halt      = 1'b0;
        bus.i_dump_data = '0;
        test_reset();
        test_load();
        test_run();
        test_step();
        test_load_full();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
